// File: rtl/cordic_rot.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rot
// Description : Iterative CORDIC rotator.
//               Rotates the vector (K_INIT, 0) by a signed angle given in
//               degrees (Q8.8). It uses one micro-rotation per clock and
//               produces cos/sin of the angle in Q2.14. The arctangent
//               table is external and is read through rom_addr/rom_data.
// Ports       : clock    - single clock, rising edge
//               reset    - asynchronous, active-high reset
//               start    - request a new rotation (ignored while busy)
//               angle    - signed target angle, degrees, Q8.8
//               rom_addr - arctangent ROM address (current iteration index)
//               rom_data - atan(2^-rom_addr) in degrees, Q8.8 (combinational)
//               cos_out  - cosine result, Q2.14, held between done pulses
//               sin_out  - sine result, Q2.14, held between done pulses
//               busy     - high while iterations are in progress
//               done     - one-cycle pulse when cos_out/sin_out update
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_rot #(
  parameter int          NITER  = 16,
  parameter logic [15:0] K_INIT = 16'd9949
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] angle,
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] cos_out,
  output logic [15:0] sin_out,
  output logic        busy,
  output logic        done
);

  // +/-90.0 degrees in Q8.8
  localparam logic signed [15:0] c_ang_max = 16'sh5A00;
  localparam logic signed [15:0] c_ang_min = 16'shA600;
  localparam logic [4:0]         c_niter   = 5'(NITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic        [4:0]  r_i;
  logic signed [15:0] r_x;
  logic signed [15:0] r_y;
  logic signed [15:0] r_z;
  logic        [15:0] r_cos;
  logic        [15:0] r_sin;
  logic               r_busy;
  logic               r_done;

  logic signed [15:0] w_angle_s;
  logic signed [15:0] w_angle_clamped;
  logic signed [15:0] w_x_sh;
  logic signed [15:0] w_y_sh;
  logic signed [15:0] w_atan;

  assign w_angle_s = $signed(angle);
  assign w_atan    = $signed(rom_data);

  // Angles beyond +/-90 degrees are outside the CORDIC convergence range
  // and are saturated at load time.
  always_comb begin
    w_angle_clamped = w_angle_s;
    if (w_angle_s > c_ang_max) begin
      w_angle_clamped = c_ang_max;
    end else if (w_angle_s < c_ang_min) begin
      w_angle_clamped = c_ang_min;
    end
  end

  // Arithmetic shifts of the pre-update vector by the iteration index.
  assign w_x_sh = r_x >>> r_i[3:0];
  assign w_y_sh = r_y >>> r_i[3:0];

  // The extra RUN cycle with r_i == NITER truncates to address 0. That
  // cycle does not read the table.
  assign rom_addr = (r_state == S_RUN) ? r_i[3:0] : 4'd0;
  assign cos_out  = r_cos;
  assign sin_out  = r_sin;
  assign busy     = r_busy;
  assign done     = r_done;

  // RUN performs NITER micro-rotations (r_i = 0..NITER-1). It then spends
  // one more cycle (r_i == NITER) that transfers the final vector to the
  // output registers while entering DONE. This gives done after edge
  // T+NITER+1 for a start sampled at edge T.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_i     <= 5'd0;
      r_x     <= 16'sd0;
      r_y     <= 16'sd0;
      r_z     <= 16'sd0;
      r_cos   <= 16'd0;
      r_sin   <= 16'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_x     <= $signed(K_INIT);
            r_y     <= 16'sd0;
            r_z     <= w_angle_clamped;
            r_i     <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_i == c_niter) begin
            r_cos   <= r_x;
            r_sin   <= r_y;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            // The sign of the residual angle picks the rotation direction.
            if (!r_z[15]) begin
              r_x <= r_x - w_y_sh;
              r_y <= r_y + w_x_sh;
              r_z <= r_z - w_atan;
            end else begin
              r_x <= r_x + w_y_sh;
              r_y <= r_y - w_x_sh;
              r_z <= r_z + w_atan;
            end
            r_i <= r_i + 5'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_rot.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_rot
// Description : Self-checking bench for cordic_rot. It supplies the
//               arctangent table, drives rotations and compares against a
//               bit-accurate arithmetic model and against ideal cos/sin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_rot;

  localparam real PI = 3.14159265358979323846;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] angle;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] cos_out;
  logic [15:0] sin_out;
  logic        busy;
  logic        done;

  logic [15:0] rom_tab [16];

  int n_cmp = 0;
  int n_err = 0;

  cordic_rot #(.NITER(16), .K_INIT(16'd9949)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .angle    (angle),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cos_out  (cos_out),
    .sin_out  (sin_out),
    .busy     (busy),
    .done     (done)
  );

  assign rom_data = rom_tab[rom_addr];

  always #5 clock = ~clock;

  // Reference: saturate the angle, then 16 plain micro-rotations with
  // 16-bit wraparound on the vector.
  function automatic void model(input logic [15:0] a,
                                output logic signed [15:0] c,
                                output logic signed [15:0] s);
    logic signed [15:0] x, y, z, xs, ys;
    int av;
    av = int'($signed(a));
    if (av > 23040) av = 23040;
    else if (av < -23040) av = -23040;
    z = 16'(av);
    x = 16'sd9949;
    y = 16'sd0;
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - $signed(rom_tab[i]);
      end else begin
        x = x + ys; y = y - xs; z = z + $signed(rom_tab[i]);
      end
    end
    c = x;
    s = y;
  endfunction

  function automatic int absdiff(input logic signed [15:0] v, input int e);
    int d;
    d = int'(v) - e;
    return (d < 0) ? -d : d;
  endfunction

  // Pulse start for one edge and wait (bounded) for done. On return, lat
  // counts edges after the load edge. sweep_ok reports busy/rom_addr
  // consistency on every RUN cycle.
  task automatic do_rotation(input logic [15:0] a,
                             output logic signed [15:0] c,
                             output logic signed [15:0] s,
                             output int lat, output bit sweep_ok);
    start = 1'b1;
    angle = a;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    sweep_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || rom_addr !== 4'(lat)) sweep_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    if (busy !== 1'b0) sweep_ok = 1'b0;
    c = cos_out;
    s = sin_out;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({cos_out, sin_out, busy, done, rom_addr} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_state: got cos=%h sin=%h busy=%b done=%b addr=%h, expected all zero",
               cos_out, sin_out, busy, done, rom_addr);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_spec_vectors;
    logic [15:0] ang [5] = '{16'h0000, 16'h1E00, 16'hD300, 16'h7F00, 16'h5A00};
    int          ec  [5] = '{16384, 14189, 11585, 0, 0};
    int          es  [5] = '{0, 8192, -11585, 16384, 16384};
    logic signed [15:0] c, s, mc, ms;
    int lat;
    bit sw;
    for (int k = 0; k < 5; k++) begin
      do_rotation(ang[k], c, s, lat, sw);
      model(ang[k], mc, ms);
      n_cmp++;
      if (lat !== 17) begin
        n_err++;
        $display("FAIL spec_latency[%h]: got %0d edges, expected 17", ang[k], lat);
      end
      n_cmp++;
      if (sw !== 1'b1) begin
        n_err++;
        $display("FAIL spec_sweep[%h]: got busy/rom_addr sequence wrong, expected busy=1 addr=0..15,0", ang[k]);
      end
      n_cmp++;
      if (absdiff(c, ec[k]) > 8 || absdiff(s, es[k]) > 8) begin
        n_err++;
        $display("FAIL spec_value[%h]: got cos=%0d sin=%0d, expected %0d %0d +/-8",
                 ang[k], c, s, ec[k], es[k]);
      end
      n_cmp++;
      if (c !== mc || s !== ms) begin
        n_err++;
        $display("FAIL spec_exact[%h]: got cos=%0d sin=%0d, expected %0d %0d",
                 ang[k], c, s, mc, ms);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic signed [15:0] c, s, mc, ms;
    int lat;
    bit sw;
    real r;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) a = 16'($urandom);
      else a = 16'($urandom_range(46080, 0) - 23040);
      do_rotation(a, c, s, lat, sw);
      model(a, mc, ms);
      n_cmp++;
      if (lat !== 17 || sw !== 1'b1 || c !== mc || s !== ms) begin
        n_err++;
        $display("FAIL random[%h]: got cos=%0d sin=%0d lat=%0d sweep=%b, expected %0d %0d 17 1",
                 a, c, s, lat, sw, mc, ms);
      end
      // Sanity against ideal trigonometry with a loose bound.
      r = real'(mc) / 16384.0;
      if (int'($signed(a)) >= -23040 && int'($signed(a)) <= 23040) begin
        r = real'(int'($signed(a))) / 256.0 * PI / 180.0;
        n_cmp++;
        if (absdiff(c, $rtoi($cos(r) * 16384.0)) > 16 || absdiff(s, $rtoi($sin(r) * 16384.0)) > 16) begin
          n_err++;
          $display("FAIL random_trig[%h]: got cos=%0d sin=%0d, expected near %0d %0d",
                   a, c, s, $rtoi($cos(r) * 16384.0), $rtoi($sin(r) * 16384.0));
        end
      end
    end
  endtask

  task automatic test_hold;
    logic signed [15:0] c, s, mc, ms;
    int lat;
    bit sw;
    bit ok;
    do_rotation(16'h2D00, c, s, lat, sw);
    model(16'h2D00, mc, ms);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      angle = 16'($urandom);
      @(posedge clock); #1;
      if (cos_out !== mc || sin_out !== ms || done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL hold: got cos=%0d sin=%0d done=%b busy=%b, expected %0d %0d 0 0",
               $signed(cos_out), $signed(sin_out), done, busy, mc, ms);
    end
  endtask

  task automatic test_busy_ignore;
    logic signed [15:0] mc, ms;
    int lat;
    bit busy_ok;
    model(16'h1E00, mc, ms);
    start = 1'b1;
    angle = 16'h1E00;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == 4) begin
        start = 1'b1;
        angle = 16'hC000;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    n_cmp++;
    if (lat !== 17 || busy_ok !== 1'b1) begin
      n_err++;
      $display("FAIL busy_ignore_timing: got lat=%0d busy_ok=%b, expected 17 1", lat, busy_ok);
    end
    n_cmp++;
    if ($signed(cos_out) !== mc || $signed(sin_out) !== ms) begin
      n_err++;
      $display("FAIL busy_ignore_value: got cos=%0d sin=%0d, expected %0d %0d",
               $signed(cos_out), $signed(sin_out), mc, ms);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_midrun;
    logic signed [15:0] c, s, mc, ms;
    int lat;
    bit sw;
    bit seen;
    start = 1'b1;
    angle = 16'hE200;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({cos_out, sin_out, busy, done, rom_addr} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_midrun_async: got cos=%h sin=%h busy=%b done=%b addr=%h, expected all zero",
               cos_out, sin_out, busy, done, rom_addr);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midrun_no_done: got activity after abort, expected none");
    end
    do_rotation(16'h1E00, c, s, lat, sw);
    model(16'h1E00, mc, ms);
    n_cmp++;
    if (lat !== 17 || sw !== 1'b1 || c !== mc || s !== ms
        || absdiff(c, 14189) > 8 || absdiff(s, 8192) > 8) begin
      n_err++;
      $display("FAIL reset_midrun_restart: got cos=%0d sin=%0d lat=%0d, expected %0d %0d 17",
               c, s, lat, mc, ms);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a [4];
    logic signed [15:0] mc, ms;
    int lat;
    bit sw;
    for (int k = 0; k < 4; k++) a[k] = 16'($urandom_range(46080, 0) - 23040);
    start = 1'b1;
    angle = a[0];
    @(posedge clock); #1;
    for (int r = 0; r < 3; r++) begin
      // Changing angle mid-RUN must not affect the result in flight.
      angle = a[r + 1];
      lat = 0;
      sw = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
        if (busy !== 1'b1 || rom_addr !== 4'(lat)) sw = 1'b0;
        @(posedge clock); #1;
        lat++;
      end
      model(a[r], mc, ms);
      n_cmp++;
      if (lat !== 17 || sw !== 1'b1 || $signed(cos_out) !== mc || $signed(sin_out) !== ms) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got cos=%0d sin=%0d lat=%0d sweep=%b, expected %0d %0d 17 1",
                 r, $signed(cos_out), $signed(sin_out), lat, sw, mc, ms);
      end
      @(posedge clock); #1;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0 || rom_addr !== 4'd0) begin
        n_err++;
        $display("FAIL back_to_back_reload[%0d]: got busy=%b done=%b addr=%h, expected 1 0 0",
                 r, busy, done, rom_addr);
      end
    end
    start = 1'b0;
    repeat (20) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    angle = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      rom_tab[k] = 16'($rtoi($atan(1.0 / real'(1 << k)) * 180.0 / PI * 256.0 + 0.5));
    end
    #1;
    test_reset;
    test_spec_vectors;
    test_random;
    test_hold;
    test_busy_ignore;
    test_reset_midrun;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
